input_fetch_ctrl: RTL
=====================

# input_fetch_ctrl

Read initiator for the dual-port input data memory. On a start command it walks a contiguous range of memory words as address pairs: even offsets on port 1, odd offsets on port 2. It captures the returned 512-bit words into a small FIFO and presents them as paired tiles to the Winograd datapath over a valid/ready handshake. The FIFO applies backpressure and the block holds off while the memory is in scan-load mode.

## Interface

Parameters:
- DATA_W, 512, width of one memory word
- ADDR_W, 8, memory address width
- CNT_W, 7, width of the pair-count input
- FIFO_DEPTH, 2, number of tile-pair entries; power of two, at least 2

Ports (clk and reset come first):
- clk  in  1  single clock for all state
- reset  in  1  asynchronous, active-low; 0 clears all state
- start  in  1  one-cycle command pulse; accepted only in IDLE
- base_addr  in  ADDR_W  first word address; sampled when start is accepted
- num_pairs  in  CNT_W  number of address pairs to fetch; sampled with start
- scan_mode  in  1  memory is being scan-loaded; no request may issue while this is 1
- addr_1_out / addr_2_out  out  ADDR_W  request addresses to memory ports 1 and 2
- package_1_valid_out / package_2_valid_out  out  1  request valids to memory ports 1 and 2
- mem_data_1_in / mem_data_2_in  in  DATA_W  read data from the memory
- mem_valid_1_in / mem_valid_2_in  in  1  returned valids from the memory
- tile_data_1_out / tile_data_2_out  out  DATA_W  FIFO head entry
- tile_valid_out  out  1  FIFO not empty
- tile_ready_in  in  1  downstream accepts the head entry
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse at the end of a command
- err  out  1  sticky; a memory return was missing or the two ports disagreed

## Operation

State machine with four states:
- IDLE, start=1 and num_pairs≠0: load ptr=base_addr, remaining=num_pairs, clear err; go to FETCH.
- IDLE, start=1 and num_pairs=0: clear err; go to DONE.
- FETCH: issue, defined as (count<FIFO_DEPTH) and scan_mode=0, drives both package valids to 1 in the same cycle.
  - On issue: ptr+=2 (mod 2^ADDR_W), remaining-=1.
  - After the issue that makes remaining reach 0: go to DRAIN.
- DRAIN: stay until the FIFO is empty (count=0), then go to DONE.
- DONE: done=1 for exactly one cycle; go to IDLE.

Request and capture rules:
- Addresses: addr_1_out=ptr, addr_2_out=ptr+1 (mod 2^ADDR_W). Both are driven from registers in every state; the valids are combinational from state, count and scan_mode.
- Memory read is a combinational bypass, so the return arrives in the issue cycle.
- On issue with mem_valid_1_in=mem_valid_2_in=1: push {mem_data_1_in, mem_data_2_in} at the clock edge.
- On issue without both returned valids: no push and err is set. The pair is counted as issued and is not retried.
- A start pulse outside IDLE is ignored. Parameter inputs are ignored except when start is accepted.
- Simultaneous push and pop is legal at any count: count is unchanged and the order is preserved.

## Timing

- Reset values: all outputs 0. FIFO is empty (count=0), ptr=0, state=IDLE.
- Reset asserted mid-command: the FIFO contents are discarded, no done pulse is produced, and the block restarts in IDLE.
- start accepted at cycle edge 0:
  - busy=1 and the first issue occur in cycle 1.
  - tile_valid_out=1 from cycle 2.
- Throughput: one pair per cycle while tile_ready_in=1. With FIFO_DEPTH=2 and continuous ready, count settles at 1.
- Full FIFO (count=FIFO_DEPTH): no issue that cycle, even if a pop occurs in the same cycle. Issue resumes the cycle after count drops.
- scan_mode=1 during FETCH: the valids are forced to 0 and ptr and remaining hold. Already-buffered tiles still drain.
- Minimum command length: N pairs with continuous ready and scan_mode=0 means done in cycle N+2 and IDLE in cycle N+3.
- num_pairs=0: done in cycle 1, with no requests issued and no tiles produced.
- Address wrap: base_addr=0xFE gives pairs (0xFE,0xFF), (0x00,0x01), and so on.

## Test plan

- Basic fetch:
  - Stimulus: memory word k = k replicated across the word; start with base=0x10, num_pairs=4, ready=1.
  - Required: four tiles, pairs (0x10,0x11) through (0x16,0x17); done in cycle 6; err=0.
- Backpressure:
  - Stimulus: same command with tile_ready_in=0 for cycles 1–5.
  - Required: exactly 2 issues (cycles 1–2); valids stay 0 until ready rises; all 4 tiles delivered in order with none lost or duplicated.
- Scan stall:
  - Stimulus: scan_mode=1 for cycles 2–4 during an 8-pair fetch.
  - Required: no package valids in cycles 2–4; address sequence continues unbroken from cycle 5; 8 tiles delivered.
- Wrap and zero-length:
  - Stimulus: base=0xFE, num_pairs=2; then a separate command with num_pairs=0.
  - Required: addresses FE/FF then 00/01. The zero-length command gives done in cycle 1 and no tiles.
- Error and reset:
  - Stimulus: force mem_valid_2_in=0 on the 2nd issue. Then assert reset mid-command with 1 tile buffered.
  - Required: err=1 sticky and 3 of 4 tiles delivered. Reset clears everything: tile_valid_out=0, busy=0, err=0, and no done pulse.

Source files
------------

// File: rtl/input_fetch_ctrl_if.sv
// Memory request/return and tile handshake bundle for input_fetch_ctrl.
// master = fetch controller side, slave = memory + Winograd datapath side.
interface input_fetch_ctrl_if #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W-1:0] addr_1_out;
  logic [ADDR_W-1:0] addr_2_out;
  logic              package_1_valid_out;
  logic              package_2_valid_out;
  logic [DATA_W-1:0] mem_data_1_in;
  logic [DATA_W-1:0] mem_data_2_in;
  logic              mem_valid_1_in;
  logic              mem_valid_2_in;
  logic [DATA_W-1:0] tile_data_1_out;
  logic [DATA_W-1:0] tile_data_2_out;
  logic              tile_valid_out;
  logic              tile_ready_in;

  modport master (
    output addr_1_out, addr_2_out, package_1_valid_out, package_2_valid_out,
    input  mem_data_1_in, mem_data_2_in, mem_valid_1_in, mem_valid_2_in,
    output tile_data_1_out, tile_data_2_out, tile_valid_out,
    input  tile_ready_in
  );

  modport slave (
    input  addr_1_out, addr_2_out, package_1_valid_out, package_2_valid_out,
    output mem_data_1_in, mem_data_2_in, mem_valid_1_in, mem_valid_2_in,
    input  tile_data_1_out, tile_data_2_out, tile_valid_out,
    output tile_ready_in
  );
endinterface

// File: rtl/input_fetch_ctrl.sv
// Read initiator for the dual-port input memory: walks address pairs, buffers the
// returned words in a small FIFO and hands them out as tile pairs.
module input_fetch_ctrl #(
  parameter int unsigned DATA_W     = 512,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned CNT_W      = 7,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    num_pairs,
  input  logic                scan_mode,
  input_fetch_ctrl_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   ptr2_q, ptr2_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic                err_q, err_d;
  logic [2*DATA_W-1:0] fifo_q [FIFO_DEPTH];
  logic [2*DATA_W-1:0] fifo_d [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                issue, push, pop, both_valid;

  assign both_valid = bus.mem_valid_1_in && bus.mem_valid_2_in;
  // A full FIFO blocks issue even if the head is popped this cycle.
  assign issue = (state_q == StFetch) && (count_q < CntW'(FIFO_DEPTH)) && !scan_mode;
  assign push  = issue && both_valid;
  assign pop   = (count_q != '0) && bus.tile_ready_in;

  always_comb begin
    fifo_d  = fifo_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push) begin
      fifo_d[wr_q] = {bus.mem_data_1_in, bus.mem_data_2_in};
      wr_d         = wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ptr2_d  = ptr2_q;
    rem_d   = rem_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          err_d = 1'b0;
          if (num_pairs != '0) begin
            ptr_d   = base_addr;
            ptr2_d  = base_addr + ADDR_W'(1);
            rem_d   = num_pairs;
            state_d = StFetch;
          end else begin
            state_d = StDone;
          end
        end
      end
      StFetch: begin
        if (issue) begin
          ptr_d  = ptr_q + ADDR_W'(2);
          ptr2_d = ptr2_q + ADDR_W'(2);
          rem_d  = rem_q - 1'b1;
          // Missing return: pair is consumed, not retried.
          if (!both_valid) err_d = 1'b1;
          if (rem_q == CNT_W'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (count_d == '0) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      ptr2_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ptr2_q  <= ptr2_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      fifo_q  <= fifo_d;
    end
  end

  assign bus.addr_1_out          = ptr_q;
  assign bus.addr_2_out          = ptr2_q;
  assign bus.package_1_valid_out = issue;
  assign bus.package_2_valid_out = issue;
  assign bus.tile_valid_out      = (count_q != '0);
  assign bus.tile_data_1_out     = fifo_q[rd_q][2*DATA_W-1:DATA_W];
  assign bus.tile_data_2_out     = fifo_q[rd_q][DATA_W-1:0];
  assign busy                    = (state_q != StIdle);
  assign done                    = (state_q == StDone);
  assign err                     = err_q;

endmodule
